// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite blitter slice.
package sprite_pkg;

  localparam int COLOR_W = 3;
  localparam logic [COLOR_W-1:0] DEFAULT_TRANSPARENT_COLOR = 3'b000;
  localparam int DEFAULT_SCREEN_X = 160;
  localparam int DEFAULT_SCREEN_Y = 120;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } blit_state_e;

endpackage

// File: rtl/sprite_blitter_if.sv
// Game-logic handshake, sprite ROM port and VGA adapter write port of the blitter.
interface sprite_blitter_if
  import sprite_pkg::*;
#(
  parameter int WIDTH_X  = 8,
  parameter int WIDTH_Y  = 7,
  parameter int SWIDTH_X = 4,
  parameter int SWIDTH_Y = 3
);
  logic                start;
  logic [WIDTH_X-1:0]  pos_x;
  logic [WIDTH_Y-1:0]  pos_y;
  logic                busy;
  logic                done;
  logic [SWIDTH_X-1:0] rom_x;
  logic [SWIDTH_Y-1:0] rom_y;
  logic [COLOR_W-1:0]  rom_color;
  logic [WIDTH_X-1:0]  vga_x;
  logic [WIDTH_Y-1:0]  vga_y;
  logic [COLOR_W-1:0]  vga_color;
  logic                vga_plot;

  modport master (
    input  start, pos_x, pos_y, rom_color,
    output busy, done, rom_x, rom_y, vga_x, vga_y, vga_color, vga_plot
  );

  modport slave (
    output start, pos_x, pos_y, rom_color,
    input  busy, done, rom_x, rom_y, vga_x, vga_y, vga_color, vga_plot
  );
endinterface

// File: rtl/blit_raster_counter.sv
// Row-major sprite-local (sx, sy) scan counter with clear, enable and last flag.
module blit_raster_counter #(
  parameter int SPRITE_W = 10,
  parameter int SPRITE_H = 6,
  parameter int SWIDTH_X = 4,
  parameter int SWIDTH_Y = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clear,
  input  logic                enable,
  output logic [SWIDTH_X-1:0] sx,
  output logic [SWIDTH_Y-1:0] sy,
  output logic                last
);
  localparam logic [SWIDTH_X-1:0] LAST_X = SWIDTH_X'(SPRITE_W - 1);
  localparam logic [SWIDTH_Y-1:0] LAST_Y = SWIDTH_Y'(SPRITE_H - 1);

  assign last = (sx == LAST_X) && (sy == LAST_Y);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      sx <= '0;
      sy <= '0;
    end else if (enable) begin
      if (sx != LAST_X) begin
        sx <= sx + 1'b1;
      end else begin
        sx <= '0;
        sy <= last ? '0 : sy + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sprite_blitter.sv
// Scans one sprite through its colour ROM and writes it to the frame buffer with clipping.
// Define SPRITE_TRANSPARENCY_EN to suppress plots of TRANSPARENT_COLOR pixels.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int WIDTH_X  = 8,
  parameter int WIDTH_Y  = 7,
  parameter int SCREEN_X = DEFAULT_SCREEN_X,
  parameter int SCREEN_Y = DEFAULT_SCREEN_Y,
  parameter int SPRITE_W = 10,
  parameter int SPRITE_H = 6,
  parameter int SWIDTH_X = 4,
  parameter int SWIDTH_Y = 3,
  parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = DEFAULT_TRANSPARENT_COLOR
) (
  input logic              clk,
  input logic              resetn,
  sprite_blitter_if.master bus
);
`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif
  localparam logic [WIDTH_X:0] SCREEN_X_L = (WIDTH_X + 1)'(SCREEN_X);
  localparam logic [WIDTH_Y:0] SCREEN_Y_L = (WIDTH_Y + 1)'(SCREEN_Y);

  blit_state_e         state_q, state_d;
  logic                cnt_clear, cnt_en, cnt_last, drain_q;
  logic [SWIDTH_X-1:0] sx, s1_sx;
  logic [SWIDTH_Y-1:0] sy, s1_sy;
  logic [WIDTH_X-1:0]  pos_x_q, vga_x_q;
  logic [WIDTH_Y-1:0]  pos_y_q, vga_y_q;
  logic [COLOR_W-1:0]  vga_color_q;
  logic                s1_valid, vga_plot_q;
  logic [WIDTH_X:0]    sum_x;
  logic [WIDTH_Y:0]    sum_y;
  logic                on_screen, opaque;

  blit_raster_counter #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .SWIDTH_X (SWIDTH_X),
    .SWIDTH_Y (SWIDTH_Y)
  ) u_raster (
    .clk    (clk),
    .resetn (resetn),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .sx     (sx),
    .sy     (sy),
    .last   (cnt_last)
  );

  // NOTE: every signal gets a default before the case so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d   = FETCH;
        cnt_clear = 1'b1;
      end
      FETCH: begin
        cnt_en = 1'b1;
        if (cnt_last) state_d = DRAIN;
      end
      DRAIN:   if (drain_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous; the whole pipeline is cleared so an aborted blit never plots.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
      pos_x_q <= '0;
      pos_y_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == DRAIN) && !drain_q;
      if (state_q == IDLE && bus.start) begin
        pos_x_q <= bus.pos_x;
        pos_y_q <= bus.pos_y;
      end
    end
  end

  // Stage 1 lines up with the registered ROM read; stage 2 drives the VGA port.
  assign sum_x     = {1'b0, pos_x_q} + (WIDTH_X + 1)'(s1_sx);
  assign sum_y     = {1'b0, pos_y_q} + (WIDTH_Y + 1)'(s1_sy);
  assign on_screen = (sum_x < SCREEN_X_L) && (sum_y < SCREEN_Y_L);
  assign opaque    = !(TRANSP_EN && (bus.rom_color == TRANSPARENT_COLOR));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid    <= 1'b0;
      s1_sx       <= '0;
      s1_sy       <= '0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      vga_plot_q  <= 1'b0;
    end else begin
      s1_valid    <= (state_q == FETCH);
      s1_sx       <= sx;
      s1_sy       <= sy;
      vga_x_q     <= sum_x[WIDTH_X-1:0];
      vga_y_q     <= sum_y[WIDTH_Y-1:0];
      vga_color_q <= bus.rom_color;
      vga_plot_q  <= s1_valid && on_screen && opaque;
    end
  end

  assign bus.rom_x     = sx;
  assign bus.rom_y     = sy;
  assign bus.vga_x     = vga_x_q;
  assign bus.vga_y     = vga_y_q;
  assign bus.vga_color = vga_color_q;
  assign bus.vga_plot  = vga_plot_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: cycle-indexed recording of every output per blit.
module tb_sprite_blitter;
  import sprite_pkg::*;

  localparam int N    = 60;
  localparam int MAXC = 160;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sprite_blitter_if #(.WIDTH_X(8), .WIDTH_Y(7), .SWIDTH_X(4), .SWIDTH_Y(3)) bus ();

  sprite_blitter #(
    .WIDTH_X(8), .WIDTH_Y(7), .SCREEN_X(160), .SCREEN_Y(120),
    .SPRITE_W(10), .SPRITE_H(6), .SWIDTH_X(4), .SWIDTH_Y(3),
    .TRANSPARENT_COLOR(3'b000)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  function automatic logic [2:0] ramp(input logic [3:0] x, input logic [2:0] y);
    logic [3:0] s;
    s = x + {1'b0, y};
    return s[2:0];
  endfunction

  // Sprite colour ROM with one-cycle registered read.
  always @(posedge clk) bus.rom_color <= ramp(bus.rom_x, bus.rom_y);

  function automatic logic exp_plot(input int px, input int py, input int k);
    logic [2:0] col;
    logic       p;
    col = ramp(4'(k % 10), 3'(k / 10));
    p = ((px + k % 10) < 160) && ((py + k / 10) < 120);
`ifdef SPRITE_TRANSPARENCY_EN
    if (col == 3'b000) p = 1'b0;
`endif
    return p;
  endfunction

  logic       r_plot[MAXC], r_busy[MAXC], r_done[MAXC];
  logic [7:0] r_x[MAXC];
  logic [6:0] r_y[MAXC];
  logic [2:0] r_col[MAXC];
  logic [3:0] r_rx[MAXC];
  logic [2:0] r_ry[MAXC];

  // Starts a blit (start sampled at edge 0) and records outputs for cycles 1..ncyc.
  task automatic run_blit(input logic [7:0] px, input logic [6:0] py, input int ncyc,
                          input int pulse_c, input int hold_until, input int rst_c);
    @(negedge clk);
    bus.start = 1'b1;
    bus.pos_x = px;
    bus.pos_y = py;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      r_plot[c] = bus.vga_plot;
      r_busy[c] = bus.busy;
      r_done[c] = bus.done;
      r_x[c]    = bus.vga_x;
      r_y[c]    = bus.vga_y;
      r_col[c]  = bus.vga_color;
      r_rx[c]   = bus.rom_x;
      r_ry[c]   = bus.rom_y;
      bus.start = (c == pulse_c) || (c < hold_until);
      if (c == rst_c) resetn = 1'b0;
      else if (c == rst_c + 2) resetn = 1'b1;
    end
    bus.start = 1'b0;
    resetn    = 1'b1;
  endtask

  task automatic test_reset;
    resetn    = 1'b0;
    bus.start = 1'b0;
    bus.pos_x = '0;
    bus.pos_y = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.vga_plot, bus.busy, bus.done, bus.vga_x, bus.vga_y, bus.vga_color,
         bus.rom_x, bus.rom_y} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: plot=%b busy=%b done=%b x=%0d y=%0d col=%0d rx=%0d ry=%0d, expected all 0",
               bus.vga_plot, bus.busy, bus.done, bus.vga_x, bus.vga_y, bus.vga_color,
               bus.rom_x, bus.rom_y);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_blit;
    int plots = 0, want_plots = 0;
    run_blit(8'd20, 7'd30, 66, -1, 0, -10);
    for (int c = 1; c <= 66; c++) begin
      int  k = c - 3;
      logic pe = (k >= 0 && k < N) ? exp_plot(20, 30, k) : 1'b0;
      tests++;
      if (r_busy[c] !== (c <= 63) || r_done[c] !== (c == 63) || r_plot[c] !== pe) begin
        fails++;
        $display("FAIL basic_ctrl c=%0d: busy=%b done=%b plot=%b, expected busy=%b done=%b plot=%b",
                 c, r_busy[c], r_done[c], r_plot[c], c <= 63, c == 63, pe);
      end
      if (c >= 1 && c <= N) begin
        tests++;
        if (r_rx[c] !== 4'((c - 1) % 10) || r_ry[c] !== 3'((c - 1) / 10)) begin
          fails++;
          $display("FAIL basic_rom_addr c=%0d: (%0d,%0d), expected (%0d,%0d)",
                   c, r_rx[c], r_ry[c], (c - 1) % 10, (c - 1) / 10);
        end
      end
      if (k >= 0 && k < N && pe) begin
        tests++;
        if (r_x[c] !== 8'(20 + k % 10) || r_y[c] !== 7'(30 + k / 10) ||
            r_col[c] !== ramp(4'(k % 10), 3'(k / 10))) begin
          fails++;
          $display("FAIL basic_pixel k=%0d: (%0d,%0d) col=%0d, expected (%0d,%0d) col=%0d",
                   k, r_x[c], r_y[c], r_col[c], 20 + k % 10, 30 + k / 10,
                   ramp(4'(k % 10), 3'(k / 10)));
        end
      end
      if (r_plot[c] === 1'b1) plots++;
      if (pe) want_plots++;
    end
    tests++;
    if (plots != want_plots) begin
      fails++;
      $display("FAIL basic_plot_count: %0d, expected %0d", plots, want_plots);
    end
  endtask

  task automatic test_clip;
    int plots = 0, want_plots = 0;
    run_blit(8'd155, 7'd117, 66, -1, 0, -10);
    for (int c = 3; c <= 62; c++) begin
      int  k = c - 3;
      logic pe = exp_plot(155, 117, k);
      tests++;
      if (r_plot[c] !== pe || r_x[c] !== 8'(155 + k % 10) || r_y[c] !== 7'(117 + k / 10)) begin
        fails++;
        $display("FAIL clip_pixel k=%0d: plot=%b (%0d,%0d), expected plot=%b (%0d,%0d)",
                 k, r_plot[c], r_x[c], r_y[c], pe, 155 + k % 10, 117 + k / 10);
      end
      if (r_plot[c] === 1'b1) plots++;
      if (pe) want_plots++;
    end
    tests++;
    if (plots != want_plots || r_done[63] !== 1'b1 || r_done[62] !== 1'b0 || r_plot[63] !== 1'b0) begin
      fails++;
      $display("FAIL clip_summary: plots=%0d done62=%b done63=%b plot63=%b, expected plots=%0d done62=0 done63=1 plot63=0",
               plots, r_done[62], r_done[63], r_plot[63], want_plots);
    end
  endtask

  task automatic test_transparency;
    logic want_plot;
`ifdef SPRITE_TRANSPARENCY_EN
    want_plot = 1'b0;
`else
    want_plot = 1'b1;
`endif
    run_blit(8'd40, 7'd50, 66, -1, 0, -10);
    tests++;
    if (r_plot[3] !== want_plot || (want_plot && r_col[3] !== 3'b000) || r_done[63] !== 1'b1) begin
      fails++;
      $display("FAIL transparent_pixel: plot=%b col=%0d done63=%b, expected plot=%b col=0 done63=1",
               r_plot[3], r_col[3], r_done[63], want_plot);
    end
  endtask

  task automatic test_start_ignored;
    int dones = 0;
    run_blit(8'd20, 7'd30, 130, 10, 0, -10);
    for (int c = 1; c <= 130; c++) if (r_done[c] === 1'b1) dones++;
    tests++;
    if (dones != 1 || r_done[63] !== 1'b1 || r_busy[64] !== 1'b0 || r_busy[70] !== 1'b0) begin
      fails++;
      $display("FAIL start_ignored: dones=%0d done63=%b busy64=%b busy70=%b, expected 1 1 0 0",
               dones, r_done[63], r_busy[64], r_busy[70]);
    end
  endtask

  task automatic test_reset_mid_blit;
    int plots = 0, dones = 0;
    run_blit(8'd20, 7'd30, 90, -1, 0, 20);
    for (int c = 21; c <= 22; c++) begin
      tests++;
      if ({r_plot[c], r_busy[c], r_done[c], r_x[c], r_y[c], r_col[c], r_rx[c], r_ry[c]} !== '0) begin
        fails++;
        $display("FAIL midreset_zero c=%0d: plot=%b busy=%b done=%b x=%0d y=%0d col=%0d, expected all 0",
                 c, r_plot[c], r_busy[c], r_done[c], r_x[c], r_y[c], r_col[c]);
      end
    end
    for (int c = 21; c <= 90; c++) begin
      if (r_plot[c] === 1'b1) plots++;
      if (r_done[c] === 1'b1) dones++;
    end
    tests++;
    if (plots != 0 || dones != 0 || r_busy[40] !== 1'b0) begin
      fails++;
      $display("FAIL midreset_quiet: plots=%0d dones=%0d busy40=%b, expected 0 0 0",
               plots, dones, r_busy[40]);
    end
    plots = 0;
    run_blit(8'd20, 7'd30, 66, -1, 0, -10);
    for (int c = 1; c <= 66; c++) if (r_plot[c] === 1'b1) plots++;
    tests++;
    if (plots != N || r_done[63] !== 1'b1 || r_plot[3] !== 1'b1 || r_plot[62] !== 1'b1) begin
      fails++;
      $display("FAIL midreset_reblit: plots=%0d done63=%b plot3=%b plot62=%b, expected 60 1 1 1",
               plots, r_done[63], r_plot[3], r_plot[62]);
    end
  endtask

  task automatic test_back_to_back;
    int d1 = -1, d2 = -1, dones = 0;
    run_blit(8'd20, 7'd30, 140, -1, 100, -10);
    for (int c = 1; c <= 140; c++) begin
      if (r_done[c] === 1'b1) begin
        dones++;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      tests++;
      if (r_busy[c] !== ((c <= 63) || (c >= 65 && c <= 127))) begin
        fails++;
        $display("FAIL b2b_busy c=%0d: %b, expected %b", c, r_busy[c],
                 (c <= 63) || (c >= 65 && c <= 127));
      end
    end
    tests++;
    if (dones != 2 || d1 != 63 || d2 != 127) begin
      fails++;
      $display("FAIL b2b_done: count=%0d first=%0d second=%0d, expected 2 63 127", dones, d1, d2);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pos_x = '0;
    bus.pos_y = '0;
    test_reset();
    test_basic_blit();
    test_clip();
    test_transparency();
    test_start_ignored();
    test_reset_mid_blit();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
